control_unit: RTL and testbench

Hardwired microsequencer for the RISC datapath. Each cycle it decodes the IR opcode and its own step counter, then drives every datapath strobe (register enables, bus-source selects, Gra/Grb/Grc, memory read/write, ALUCode) through fetch and execute steps. It replaces bench-driven T-state stimulus; its outputs connect one-to-one to the DataPath control inputs.

---
 rtl/cu_pkg.sv | 36 +++
 rtl/control_unit_if.sv | 27 ++
 rtl/cu_decode.sv | 31 +++
 rtl/control_unit.sv | 103 ++++++++++
 tb/tb_control_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcode, ALU-code, state and instruction-class definitions for the control unit.
package cu_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_INC = 5'b11111;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR, C_SINGLE, C_HALT, C_NOP
    } iclass_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: IR/condition inputs and every datapath strobe driven by the control unit.
//   master: control unit side (reads IR, ConOut; drives strobes, ALUCode, Run)
//   slave : datapath side
interface control_unit_if;
    logic [31:0] IR;
    logic        ConOut;
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin;
    logic        memread, memwrite;
    logic [4:0]  ALUCode;
    logic        Run;

    modport master (
        input  IR, ConOut,
        output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
               HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
               Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, ALUCode, Run
    );

    modport slave (
        output IR, ConOut,
        input  HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
               HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
               Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, ALUCode, Run
    );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: maps an opcode to its instruction class and the ALU code used by its ZIn step.
//   op_i  : IR[31:27]
//   cls_o : instruction class
//   alu_o : ALU operation for the execute-phase ZIn step (0 if none)
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] op_i,
    output iclass_t    cls_o,
    output logic [4:0] alu_o
);
    always_comb begin
        cls_o = C_NOP;
        alu_o = '0;
        case (op_i) inside
            [OP_ADD:OP_SHL]: begin cls_o = C_ALU3; alu_o = op_i; end
            OP_ADDI: begin cls_o = C_IMM; alu_o = ALU_ADD; end
            OP_ANDI: begin cls_o = C_IMM; alu_o = ALU_AND; end
            OP_ORI: begin cls_o = C_IMM; alu_o = ALU_OR; end
            OP_MUL, OP_DIV: begin cls_o = C_MULDIV; alu_o = op_i; end
            OP_NEG, OP_NOT: begin cls_o = C_UNARY; alu_o = op_i; end
            OP_LD: begin cls_o = C_LD; alu_o = ALU_ADD; end
            OP_LDI: begin cls_o = C_LDI; alu_o = ALU_ADD; end
            OP_ST: begin cls_o = C_ST; alu_o = ALU_ADD; end
            OP_BR: begin cls_o = C_BR; alu_o = ALU_ADD; end
            OP_JR, OP_IN, OP_OUT, OP_MFLO, OP_MFHI: cls_o = C_SINGLE;
            OP_HALT: cls_o = C_HALT;
            default: cls_o = C_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired microsequencer driving datapath strobes through fetch/execute steps.
//   clock : state register updates on the falling edge (datapath captures on rising)
//   clear : synchronous active-high reset to RST
//   bus   : IR/ConOut in, all strobes, ALUCode and Run out
module control_unit
    import cu_pkg::*;
(
    input logic           clock,
    input logic           clear,
    control_unit_if.master bus
);
    state_t     state_q, state_d;
    iclass_t    cls;
    logic [4:0] alu;
    logic [4:0] op;

    assign op = bus.IR[31:27];

    cu_decode u_decode (.op_i(op), .cls_o(cls), .alu_o(alu));

    always_ff @(negedge clock) state_q <= clear ? S_RST : state_d;

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: state_d = cls == C_HALT ? S_HALT : cls inside {C_SINGLE, C_NOP} ? S_T0 : S_T4;
            S_T4: state_d = cls == C_UNARY ? S_T0 : S_T5;
            S_T5: state_d = cls inside {C_ALU3, C_IMM, C_LDI} ? S_T0 : S_T6;
            S_T6: state_d = cls inside {C_MULDIV, C_BR} ? S_T0 : S_T7;
            S_T7: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        bus.HiIn = 1'b0; bus.LoIn = 1'b0; bus.ZIn = 1'b0; bus.PCIn = 1'b0;
        bus.MDRIn = 1'b0; bus.MARIn = 1'b0; bus.YIn = 1'b0; bus.OPortIn = 1'b0;
        bus.IRIn = 1'b0; bus.HiOut = 1'b0; bus.LoOut = 1'b0; bus.ZHiOut = 1'b0;
        bus.ZLoOut = 1'b0; bus.PCOut = 1'b0; bus.MDROut = 1'b0; bus.IPortOut = 1'b0;
        bus.COut = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.RIn = 1'b0; bus.ROut = 1'b0; bus.BAOut = 1'b0; bus.Conin = 1'b0;
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        case (state_q)
            S_T0: begin bus.PCOut = 1'b1; bus.MARIn = 1'b1; bus.ZIn = 1'b1; end
            S_T1: begin bus.ZLoOut = 1'b1; bus.PCIn = 1'b1; bus.memread = 1'b1; bus.MDRIn = 1'b1; end
            S_T2: begin bus.MDROut = 1'b1; bus.IRIn = 1'b1; end
            S_T3: case (cls)
                C_ALU3, C_IMM: begin bus.Grb = 1'b1; bus.ROut = 1'b1; bus.YIn = 1'b1; end
                C_MULDIV: begin bus.Gra = 1'b1; bus.ROut = 1'b1; bus.YIn = 1'b1; end
                C_UNARY: begin bus.Grb = 1'b1; bus.ROut = 1'b1; bus.ZIn = 1'b1; end
                C_LD, C_LDI, C_ST: begin bus.Grb = 1'b1; bus.BAOut = 1'b1; bus.YIn = 1'b1; end
                C_BR: begin bus.Gra = 1'b1; bus.ROut = 1'b1; bus.Conin = 1'b1; end
                C_SINGLE: begin
                    bus.Gra = 1'b1;
                    bus.ROut = op inside {OP_JR, OP_OUT};
                    bus.PCIn = op == OP_JR;
                    bus.OPortIn = op == OP_OUT;
                    bus.RIn = op inside {OP_IN, OP_MFLO, OP_MFHI};
                    bus.IPortOut = op == OP_IN;
                    bus.LoOut = op == OP_MFLO;
                    bus.HiOut = op == OP_MFHI;
                end
                default: ;
            endcase
            S_T4: case (cls)
                C_ALU3: begin bus.Grc = 1'b1; bus.ROut = 1'b1; bus.ZIn = 1'b1; end
                C_IMM, C_LD, C_LDI, C_ST: begin bus.COut = 1'b1; bus.ZIn = 1'b1; end
                C_MULDIV: begin bus.Grb = 1'b1; bus.ROut = 1'b1; bus.ZIn = 1'b1; end
                C_UNARY: begin bus.ZLoOut = 1'b1; bus.Gra = 1'b1; bus.RIn = 1'b1; end
                C_BR: begin bus.PCOut = 1'b1; bus.YIn = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                C_ALU3, C_IMM, C_LDI: begin bus.ZLoOut = 1'b1; bus.Gra = 1'b1; bus.RIn = 1'b1; end
                C_MULDIV: begin bus.ZLoOut = 1'b1; bus.LoIn = 1'b1; end
                C_LD, C_ST: begin bus.ZLoOut = 1'b1; bus.MARIn = 1'b1; end
                C_BR: begin bus.COut = 1'b1; bus.ZIn = 1'b1; end
                default: ;
            endcase
            S_T6: case (cls)
                C_MULDIV: begin bus.ZHiOut = 1'b1; bus.HiIn = 1'b1; end
                C_LD: begin bus.memread = 1'b1; bus.MDRIn = 1'b1; end
                C_ST: begin bus.Gra = 1'b1; bus.ROut = 1'b1; bus.MDRIn = 1'b1; end
                C_BR: begin bus.ZLoOut = 1'b1; bus.PCIn = bus.ConOut; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD: begin bus.MDROut = 1'b1; bus.Gra = 1'b1; bus.RIn = 1'b1; end
                C_ST: bus.memwrite = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
        // ALUCode is only meaningful when Z is being loaded; fetch increments PC.
        bus.ALUCode = !bus.ZIn ? 5'b00000 : state_q == S_T0 ? ALU_INC : alu;
        bus.Run = !(state_q inside {S_RST, S_HALT});
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked against a step-table model of the control unit.
module tb_control_unit;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    control_unit_if bus ();
    control_unit dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    string names [26] = '{"HiIn", "LoIn", "ZIn", "PCIn", "MDRIn", "MARIn", "YIn", "OPortIn", "IRIn",
                          "HiOut", "LoOut", "ZHiOut", "ZLoOut", "PCOut", "MDROut", "IPortOut", "COut",
                          "Gra", "Grb", "Grc", "RIn", "ROut", "BAOut", "Conin", "memread", "memwrite"};

    string      m_s [$];
    logic [4:0] m_a [$];

    function automatic logic [25:0] strobes();
        return {bus.HiIn, bus.LoIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.MARIn, bus.YIn, bus.OPortIn, bus.IRIn,
                bus.HiOut, bus.LoOut, bus.ZHiOut, bus.ZLoOut, bus.PCOut, bus.MDROut, bus.IPortOut, bus.COut,
                bus.Gra, bus.Grb, bus.Grc, bus.RIn, bus.ROut, bus.BAOut, bus.Conin, bus.memread, bus.memwrite};
    endfunction

    function automatic logic [25:0] mask(string s);
        logic [25:0] m = '0;
        string tok = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                for (int j = 0; j < 26; j++) if (tok == names[j]) m[25-j] = 1'b1;
                tok = "";
            end else tok = {tok, s.substr(i, i)};
        end
        return m;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic add(string s, logic [4:0] a);
        m_s.push_back(s);
        m_a.push_back(a);
    endtask

    task automatic build(logic [4:0] op, bit con);
        m_s.delete();
        m_a.delete();
        add("PCOut MARIn ZIn", 5'b11111);
        add("ZLoOut PCIn memread MDRIn", 5'd0);
        add("MDROut IRIn", 5'd0);
        if (op >= 3 && op <= 11) begin
            add("Grb ROut YIn", 5'd0); add("Grc ROut ZIn", op); add("ZLoOut Gra RIn", 5'd0);
        end else if (op >= 12 && op <= 14) begin
            add("Grb ROut YIn", 5'd0);
            add("COut ZIn", op == 12 ? 5'b00011 : op == 13 ? 5'b00101 : 5'b00110);
            add("ZLoOut Gra RIn", 5'd0);
        end else if (op == 15 || op == 16) begin
            add("Gra ROut YIn", 5'd0); add("Grb ROut ZIn", op); add("ZLoOut LoIn", 5'd0); add("ZHiOut HiIn", 5'd0);
        end else if (op == 17 || op == 18) begin
            add("Grb ROut ZIn", op); add("ZLoOut Gra RIn", 5'd0);
        end else if (op <= 2) begin
            add("Grb BAOut YIn", 5'd0); add("COut ZIn", 5'b00011);
            if (op == 1) add("ZLoOut Gra RIn", 5'd0);
            else begin
                add("ZLoOut MARIn", 5'd0);
                if (op == 0) begin add("memread MDRIn", 5'd0); add("MDROut Gra RIn", 5'd0); end
                else begin add("Gra ROut MDRIn", 5'd0); add("memwrite", 5'd0); end
            end
        end else if (op == 19) begin
            add("Gra ROut Conin", 5'd0); add("PCOut YIn", 5'd0); add("COut ZIn", 5'b00011);
            add(con ? "ZLoOut PCIn" : "ZLoOut", 5'd0);
        end else if (op == 21) add("Gra ROut PCIn", 5'd0);
        else if (op == 22) add("IPortOut Gra RIn", 5'd0);
        else if (op == 23) add("Gra ROut OPortIn", 5'd0);
        else if (op == 24) add("LoOut Gra RIn", 5'd0);
        else if (op == 25) add("HiOut Gra RIn", 5'd0);
        else add("", 5'd0);
    endtask

    task automatic check_idle(string tag);
        check({tag, " strobes"}, 32'(strobes()), 32'd0);
        check({tag, " alu"}, 32'(bus.ALUCode), 32'd0);
        check({tag, " run"}, 32'(bus.Run), 32'd0);
    endtask

    // Entered just after a falling edge with the DUT in T0; leaves just after the
    // falling edge that ends the instruction. clear_at >= 0 asserts clear in that step.
    task automatic run_instr(logic [31:0] ir, bit con, int clear_at);
        string tag;
        bus.IR = ir;
        bus.ConOut = con;
        build(ir[31:27], con);
        for (int k = 0; k < m_s.size(); k++) begin
            tag = $sformatf("op%02h k%0d", ir[31:27], k);
            if (k == clear_at) clear = 1'b1;
            @(posedge clock);
            check({tag, " strobes"}, 32'(strobes()), 32'(mask(m_s[k])));
            check({tag, " alu"}, 32'(bus.ALUCode), 32'(m_a[k]));
            check({tag, " run"}, 32'(bus.Run), 32'd1);
            @(negedge clock);
            #1;
            if (k == clear_at) begin
                @(posedge clock);
                check_idle({tag, " midrst"});
                clear = 1'b0;
                @(negedge clock);
                #1;
                return;
            end
        end
    endtask

    task automatic expect_t0(string tag);
        @(posedge clock);
        check({tag, " strobes"}, 32'(strobes()), 32'(mask("PCOut MARIn ZIn")));
        check({tag, " alu"}, 32'(bus.ALUCode), 32'b11111);
        @(negedge clock);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        bus.IR = '0;
        bus.ConOut = 1'b0;
        repeat (2) @(negedge clock);
        @(posedge clock);
        check_idle("reset");
        clear = 1'b0;
        @(negedge clock);
        #1;
        run_instr(32'h6B10_0007, 1'b0, -1);
        run_instr({5'b00000, 27'h123}, 1'b0, -1);
        run_instr({5'b00010, 27'h456}, 1'b0, -1);
        run_instr({5'b10011, 27'h0}, 1'b0, -1);
        run_instr({5'b10011, 27'h0}, 1'b1, -1);
        run_instr({5'b11111, 27'h0}, 1'b0, -1);
        run_instr({5'b10000, 27'h789}, 1'b0, 5);
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b10100;
            run_instr({op, 27'($urandom)}, 1'($urandom), -1);
        end
        run_instr({5'b11011, 27'h0}, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            check_idle($sformatf("halt c%0d", i));
            @(negedge clock);
            #1;
        end
        clear = 1'b1;
        @(posedge clock);
        check_idle("halt pre-clear");
        @(negedge clock);
        #1;
        @(posedge clock);
        check_idle("halt rst");
        clear = 1'b0;
        @(negedge clock);
        #1;
        expect_t0("after halt");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
